// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding, default frame
// geometry and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned DEF_STOP_BITS = 1;
  localparam int unsigned MAX_DATA_BITS = 9;

  // Zero-extension to MAX_DATA_BITS leaves the XOR reduction unchanged.
  function automatic logic frame_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word over valid/ready and serialises it as
// start bit, LSB-first data, optional parity and stop bits, one bit per baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DataBits  = DEF_DATA_BITS,
  parameter int unsigned StopBits  = DEF_STOP_BITS,
  parameter int unsigned ParityEn  = 0,
  parameter int unsigned ParityOdd = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_tick,
  output logic                baud_en,
  input  logic [DataBits-1:0] data_in,
  input  logic                valid,
  output logic                ready,
  output logic                tx,
  output logic                busy,
  output logic                tx_done
);

  localparam int unsigned IDX_W = $clog2(DataBits);

  state_e              state;
  state_e              state_next;
  logic [DataBits-1:0] shift_reg;
  logic [IDX_W-1:0]    bit_idx;
  logic                stop_cnt;
  logic                parity_bit;
  logic                last_bit;
  logic                last_stop;

  assign last_bit  = (bit_idx == IDX_W'(DataBits - 1));
  assign last_stop = (stop_cnt == 1'(StopBits - 1));

  assign ready   = (state == IDLE);
  assign busy    = (state != IDLE);
  assign baud_en = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid) state_next = ARMED;
      ARMED:   if (baud_tick) state_next = START;
      START:   if (baud_tick) state_next = DATA;
      DATA:    if (baud_tick && last_bit) state_next = (ParityEn != 0) ? PARITY : STOP;
      PARITY:  if (baud_tick) state_next = STOP;
      STOP:    if (baud_tick && last_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The word is shifted out, so parity is captured from data_in at accept time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      shift_reg  <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            shift_reg  <= data_in;
            parity_bit <= frame_parity(MAX_DATA_BITS'(data_in), ParityOdd != 0);
          end
        end
        ARMED: begin
          if (baud_tick) tx <= 1'b0;
        end
        START: begin
          if (baud_tick) begin
            tx      <= shift_reg[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (last_bit) begin
              if (ParityEn != 0) begin
                tx <= parity_bit;
              end else begin
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              tx        <= shift_reg[1];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (last_stop) tx_done  <= 1'b1;
            else           stop_cnt <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter that consumes the single-cycle baud tick produced by the clock divider. It turns one parallel byte, accepted via a valid/ready handshake, into an asynchronous UART frame: start bit, LSB-first data, optional parity, then stop bits. Every bit period is exactly one tick interval. It sits between the CPU's memory-mapped UART register and the pad; the enclosing uart top instantiates clock_divider and uart_tx side by side.

Parameters:
DataBits, 8, data bits per frame, 5..9
StopBits, 1, stop bits per frame, 1 or 2
ParityEn, 0, 1 = append parity bit after data
ParityOdd, 0, 1 = odd parity, 0 = even (only when ParityEn=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
baud_tick  in  1  one-cycle pulse per bit period (clock_divider clk_out)
baud_en  out  1  enable for the divider; high whenever state != IDLE
data_in  in  DataBits  byte to send; sampled only on accept
valid  in  1  data_in is offered
ready  out  1  high iff state == IDLE (combinational from state)
tx  out  1  serial line, registered, idle-high
busy  out  1  high iff state != IDLE
tx_done  out  1  registered one-cycle pulse when the final stop bit period ends

Behaviour:
- Reset (async, any state): state=IDLE, tx=1, tx_done=0, shift reg=0, bit_idx=0, stop_cnt=0. Hence ready=1, busy=0, baud_en=0. A frame in flight is aborted; the line returns high immediately.
- Accept: a rising edge with valid&&ready latches data_in into the shift reg and moves state to ARMED. A tick on the same edge is ignored.
- ARMED: tx stays 1. On the first edge with baud_tick=1, tx<=0 and state goes to START. This aligns the start bit to a full tick period.
- START: on tick, tx<=shift[0], bit_idx<=0, state goes to DATA.
- DATA: on tick, if bit_idx==DataBits-1:
  - ParityEn=1: tx<=parity, state goes to PARITY.
  - otherwise: tx<=1, stop_cnt<=0, state goes to STOP.
  - else: bit_idx++ and tx<=next data bit.
- PARITY: parity = XOR of latched data, inverted when ParityOdd. On tick, tx<=1, stop_cnt<=0, state goes to STOP.
- STOP: on tick, if stop_cnt==StopBits-1, state goes to IDLE and tx_done<=1 for that one cycle; else stop_cnt++.
- Ticks arriving in IDLE are ignored. Without a tick, every state holds and tx is stable.
- Back-to-back: ready rises the cycle after the frame ends, so a new accept is possible then. The line stays high until the next ARMED tick, which guarantees at least StopBits of idle.
- valid may drop without an accept; there is no requirement on the sender. data_in is a don't-care outside accept.
- bit_idx width = $clog2(DataBits); stop_cnt is 1 bit.
- Frame length, accept to tx_done = (1 + DataBits + ParityEn + StopBits) tick periods plus the ARMED wait.

Decomposition:
- Shared uart_pkg holds:
  - state_e enum {IDLE, ARMED, START, DATA, PARITY, STOP}
  - the parity helper function
  - default DataBits/StopBits constants, shared with the future uart_rx
- No sub-module; the shift register and counters are inline.
- The uart top wires clock_divider.clk_out to baud_tick and baud_en to the divider's enable.

Test Plan:
- Tick every 4 cycles, defaults, send 0x55 -> tx after ARMED: 0, 1,0,1,0,1,0,1,0, 1, each held 4 cycles. tx_done pulses once; ready returns 1 the next cycle.
- ParityEn=1, ParityOdd=0, send 0x07 -> parity bit 1. With ParityOdd=1 -> parity bit 0. Frame is 11 bit periods.
- StopBits=2, send 0xFF then 0x00 back-to-back (valid held high) -> line high for at least 2 tick periods between frames. Second start bit aligns to a tick. Two tx_done pulses.
- valid asserted on the same edge as baud_tick in IDLE -> that tick is not consumed. Start bit begins on the next tick; the ARMED period lasts one full tick interval.
- Assert rst during DATA bit 3 -> tx=1 and busy=0 asynchronously. After release, ready=1, no tx_done, and a new 0xA5 frame transmits correctly.
- Hold baud_tick=0 for 100 cycles mid-frame -> tx and state frozen, no spurious tx_done.
